register_bank_shadowed: RTL and testbench
=========================================

# register_bank_shadowed

Parametrised successor to the team's flat register block. It sits between the UART command parser and the design's configuration consumers. It adds per-word write lanes, a shadow (staging) copy with atomic commit/discard, a sticky write lock, a saturating write-error counter and a read-only status window. Consumers see only the committed image on `o_mem`, so a multi-register reconfiguration sent over UART takes effect in a single clock.

## Interface
Parameters:
- `WORD_WIDTH`, 8: bits per word; also the address width.
- `REG_WIDTH`, 4: words per register; register width `W = WORD_WIDTH*REG_WIDTH`.
- `REG_DEPTH`, 16: number of configuration registers, at addresses `0..REG_DEPTH-1`.
- `NUM_STATUS`, 2: read-only status registers, at addresses `REG_DEPTH+2 .. REG_DEPTH+1+NUM_STATUS`.
- `ERR_WIDTH`, 8: width of the error counter; must be ≤ W.
- Legality: `REG_DEPTH+2+NUM_STATUS ≤ 2**WORD_WIDTH`.

Ports:
- `clk`, in, 1: clock; all logic is on the rising edge.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_w_en`, in, 1: write strobe, single cycle.
- `i_w_addr`, in, WORD_WIDTH: write address.
- `i_w_value`, in, W: write data.
- `i_w_lane`, in, REG_WIDTH: per-word write enable; bit k covers bits `[k*WORD_WIDTH +: WORD_WIDTH]`.
- `i_r_en`, in, 1: read strobe.
- `i_r_addr`, in, WORD_WIDTH: read address.
- `o_r_value`, out, W: read data.
- `o_r_valid`, out, 1: read data valid, single-cycle pulse.
- `o_r_err`, out, 1: pulses with `o_r_valid` when the read address was unmapped.
- `i_status`, in, W×NUM_STATUS (unpacked `[NUM_STATUS-1:0]`): live status values.
- `o_mem`, out, W×REG_DEPTH (unpacked `[REG_DEPTH-1:0]`): committed (active) register image.
- `o_commit`, out, 1: pulses in the cycle `o_mem` takes a committed image.
- `o_locked`, out, 1: lock state.

## Operation
- Address map:
  - `0..REG_DEPTH-1`: configuration registers, read/write, backed by staging.
  - `CTRL = REG_DEPTH`: control register, write-only actions; reads return `{…0, o_locked, 2'b0}`.
  - `ERRC = REG_DEPTH+1`: error counter, read-only, zero-extended to W.
  - Above `ERRC`: status registers. Anything beyond the status window is unmapped.
- Configuration write, not locked: each staging word with its lane bit set takes the matching `i_w_value` word; words with lane bits clear are unchanged. `o_mem` is unchanged.
- Control write: honoured only if lane 0 is set; fields are taken from bits of word 0.
  - bit0 COMMIT: copy staging → active for all registers.
  - bit1 DISCARD: copy active → staging.
  - bit2 LOCK: set the lock. The lock is sticky; only reset clears it.
  - COMMIT and DISCARD together: COMMIT wins and DISCARD is ignored.
  - LOCK with COMMIT in the same write: the commit executes, then the lock applies.
- Lock state machine: UNLOCKED → LOCKED on LOCK; LOCKED is exit-only by reset. While LOCKED:
  - configuration writes are ignored;
  - COMMIT and DISCARD are ignored;
  - each such ignored write increments the error counter.
- Error counter also increments on:
  - any write to ERRC, the status window or an unmapped address;
  - a control write with lane 0 clear.
- The error counter saturates at `2**ERR_WIDTH-1`. It is never cleared except by reset.
- Reads:
  - configuration address → staging value;
  - status address → `i_status` sampled at the `i_r_en` edge;
  - unmapped address → zero, with `o_r_err=1`.

## Timing
- Reset values:
  - staging, active and `o_mem`: all 0;
  - `o_r_value`: 0; `o_r_valid`, `o_r_err`, `o_commit`, `o_locked`: 0;
  - error counter: 0; lock state: UNLOCKED.
- Write latency: staging is updated at the edge that samples `i_w_en`, so a read issued in the next cycle sees the new value.
- Commit latency: `o_mem` and `o_commit` update at the edge sampling the COMMIT write; they are visible in the following cycle. All registers switch in the same cycle.
- Read latency 1: `o_r_valid`, `o_r_value` and `o_r_err` are registered. They are valid in the cycle after `i_r_en` and low otherwise. `o_r_value` holds its last value when not valid.
- Back-to-back reads are accepted every cycle.
- Same-cycle read and write to the same address: the read returns the pre-write value.
- Same-cycle read of ERRC with an error-causing write: the read returns the pre-increment count.
- No backpressure: every strobe is accepted.
- Reset asserted mid-operation clears everything immediately. Any in-flight read response is dropped.

## Configuration
- `REGISTER_BANK_SHADOW_EN` defined: shadow staging, COMMIT and DISCARD behave as above.
- `REGISTER_BANK_SHADOW_EN` undefined:
  - there is no staging storage; configuration writes update active and `o_mem` directly, one cycle after the write;
  - reads of configuration addresses return active;
  - COMMIT and DISCARD bits are ignored and do not count as errors;
  - `o_commit` is tied to 0;
  - lock and error counter behaviour is unchanged.

## Test plan
- Reset, then read addresses 0, CTRL and ERRC → each read returns 0 with `o_r_valid` one cycle later and `o_r_err=0`; `o_mem` all zeros.
- Write addr 3 with value `0xAABBCCDD` and lanes `4'b0101`, then read addr 3 → `0x00BB00DD`; `o_mem[3]` stays 0. Write CTRL with `0x1` → `o_commit` pulses for one cycle and `o_mem[3]=0x00BB00DD` in the next cycle.
- Stage addr 5 with `0x12345678`, write CTRL with `0x2`, then read addr 5 → 0; `o_mem[5]` stays 0; no `o_commit`.
- Write CTRL with `0x4`, then write addr 0 with `0xFFFFFFFF` and write CTRL with `0x1` → `o_locked=1`, `o_mem[0]=0`, and ERRC reads back 2. Drive 260 further errors with `ERR_WIDTH=8` → ERRC saturates at 255.
- Drive `i_status[1]=0xCAFEF00D` and read address `REG_DEPTH+3` → `0xCAFEF00D`. Read address `0xFF` → value 0 with `o_r_err=1`.
- In the same cycle, write addr 2 with `0x11` and read addr 2 → the read returns the old value 0; a read in the next cycle returns `0x11`. Assert reset on the cycle after `i_r_en` → `o_r_valid` stays 0.

Source files
------------

// File: rtl/register_bank_shadowed.sv
// Shadowed configuration register bank with per-word write lanes, sticky lock,
// saturating error counter and read-only status window. Macro: REGISTER_BANK_SHADOW_EN.
module register_bank_shadowed #(
  parameter int WORD_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int REG_DEPTH  = 16,
  parameter int NUM_STATUS = 2,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            i_reset,
  input  logic                            i_w_en,
  input  logic [WORD_WIDTH-1:0]           i_w_addr,
  input  logic [WORD_WIDTH*REG_WIDTH-1:0] i_w_value,
  input  logic [REG_WIDTH-1:0]            i_w_lane,
  input  logic                            i_r_en,
  input  logic [WORD_WIDTH-1:0]           i_r_addr,
  output logic [WORD_WIDTH*REG_WIDTH-1:0] o_r_value,
  output logic                            o_r_valid,
  output logic                            o_r_err,
  input  logic [WORD_WIDTH*REG_WIDTH-1:0] i_status [NUM_STATUS-1:0],
  output logic [WORD_WIDTH*REG_WIDTH-1:0] o_mem [REG_DEPTH-1:0],
  output logic                            o_commit,
  output logic                            o_locked
);

  localparam int W = WORD_WIDTH * REG_WIDTH;
  localparam logic [WORD_WIDTH-1:0] CTRL_ADDR = WORD_WIDTH'(REG_DEPTH);
  localparam logic [WORD_WIDTH-1:0] ERRC_ADDR = WORD_WIDTH'(REG_DEPTH + 1);
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ERR_WIDTH-1:0] errCnt_q, errCnt_d;
  logic [W-1:0]         active_q [REG_DEPTH-1:0];
  logic [W-1:0]         active_d [REG_DEPTH-1:0];
  logic [W-1:0]         cfgView  [REG_DEPTH-1:0];
  logic                 commit_q, commit_d;
  logic [W-1:0]         rValue_q, rValue_d;
  logic                 rValid_q;
  logic                 rErr_q, rErr_d;
  logic                 locked;
  logic                 errHit;

`ifdef REGISTER_BANK_SHADOW_EN
  logic [W-1:0]         staging_q [REG_DEPTH-1:0];
  logic [W-1:0]         staging_d [REG_DEPTH-1:0];
  assign cfgView = staging_q;
`else
  assign cfgView = active_q;
`endif

  assign locked = (state_q == ST_LOCKED);

  // Write decode: staging/active updates, control actions, lock and error accounting.
  always_comb begin
    active_d = active_q;
`ifdef REGISTER_BANK_SHADOW_EN
    staging_d = staging_q;
`endif
    state_d  = state_q;
    errCnt_d = errCnt_q;
    commit_d = 1'b0;
    errHit   = 1'b0;
    if (i_w_en) begin
      if (i_w_addr < CTRL_ADDR) begin
        if (locked) begin
          errHit = 1'b1;
        end else begin
          for (int r = 0; r < REG_DEPTH; r++) begin
            if (i_w_addr == WORD_WIDTH'(r)) begin
              for (int k = 0; k < REG_WIDTH; k++) begin
                if (i_w_lane[k]) begin
`ifdef REGISTER_BANK_SHADOW_EN
                  staging_d[r][k*WORD_WIDTH +: WORD_WIDTH] = i_w_value[k*WORD_WIDTH +: WORD_WIDTH];
`else
                  active_d[r][k*WORD_WIDTH +: WORD_WIDTH] = i_w_value[k*WORD_WIDTH +: WORD_WIDTH];
`endif
                end
              end
            end
          end
        end
      end else if (i_w_addr == CTRL_ADDR) begin
        if (!i_w_lane[0]) begin
          errHit = 1'b1;
        end else begin
`ifdef REGISTER_BANK_SHADOW_EN
          // Commit takes priority over discard; the old lock state gates both.
          if (locked) begin
            if (i_w_value[0] || i_w_value[1]) errHit = 1'b1;
          end else if (i_w_value[0]) begin
            active_d = staging_q;
            commit_d = 1'b1;
          end else if (i_w_value[1]) begin
            staging_d = active_q;
          end
`endif
          if (i_w_value[2]) state_d = ST_LOCKED;
        end
      end else begin
        errHit = 1'b1;
      end
    end
    if (errHit && (errCnt_q != ERR_MAX)) errCnt_d = errCnt_q + ERR_WIDTH'(1);
  end

  // Read decode works from current register state, so same-cycle writes are not visible.
  always_comb begin
    rValue_d = '0;
    rErr_d   = 1'b0;
    if (i_r_addr < CTRL_ADDR) begin
      for (int r = 0; r < REG_DEPTH; r++) begin
        if (i_r_addr == WORD_WIDTH'(r)) rValue_d = cfgView[r];
      end
    end else if (i_r_addr == CTRL_ADDR) begin
      rValue_d = W'({locked, 2'b00});
    end else if (i_r_addr == ERRC_ADDR) begin
      rValue_d = W'(errCnt_q);
    end else begin
      rErr_d = 1'b1;
      for (int s = 0; s < NUM_STATUS; s++) begin
        if (i_r_addr == WORD_WIDTH'(REG_DEPTH + 2 + s)) begin
          rValue_d = i_status[s];
          rErr_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_UNLOCKED;
      errCnt_q <= '0;
      commit_q <= 1'b0;
      rValue_q <= '0;
      rValid_q <= 1'b0;
      rErr_q   <= 1'b0;
      for (int r = 0; r < REG_DEPTH; r++) begin
        active_q[r] <= '0;
`ifdef REGISTER_BANK_SHADOW_EN
        staging_q[r] <= '0;
`endif
      end
    end else begin
      state_q  <= state_d;
      errCnt_q <= errCnt_d;
      commit_q <= commit_d;
      rValid_q <= i_r_en;
      rErr_q   <= i_r_en & rErr_d;
      if (i_r_en) rValue_q <= rValue_d;
      active_q <= active_d;
`ifdef REGISTER_BANK_SHADOW_EN
      staging_q <= staging_d;
`endif
    end
  end

  assign o_mem     = active_q;
  assign o_commit  = commit_q;
  assign o_locked  = locked;
  assign o_r_value = rValue_q;
  assign o_r_valid = rValid_q;
  assign o_r_err   = rErr_q;

endmodule

// File: tb/tb_register_bank_shadowed.sv
// Directed, table-driven bench for register_bank_shadowed; expectations follow
// whichever REGISTER_BANK_SHADOW_EN build is being compiled.
module tb_register_bank_shadowed;

  localparam int WW = 8;
  localparam int RW = 4;
  localparam int W  = WW * RW;
  localparam int RD = 16;
  localparam int NS = 2;
  localparam int EW = 8;

`ifdef REGISTER_BANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic          clk;
  logic          i_reset;
  logic          i_w_en;
  logic [WW-1:0] i_w_addr;
  logic [W-1:0]  i_w_value;
  logic [RW-1:0] i_w_lane;
  logic          i_r_en;
  logic [WW-1:0] i_r_addr;
  logic [W-1:0]  o_r_value;
  logic          o_r_valid;
  logic          o_r_err;
  logic [W-1:0]  i_status [NS-1:0];
  logic [W-1:0]  o_mem [RD-1:0];
  logic          o_commit;
  logic          o_locked;

  int nCompared = 0;
  int nMismatched = 0;

  register_bank_shadowed #(
    .WORD_WIDTH(WW), .REG_WIDTH(RW), .REG_DEPTH(RD), .NUM_STATUS(NS), .ERR_WIDTH(EW)
  ) dut (
    .clk(clk), .i_reset(i_reset),
    .i_w_en(i_w_en), .i_w_addr(i_w_addr), .i_w_value(i_w_value), .i_w_lane(i_w_lane),
    .i_r_en(i_r_en), .i_r_addr(i_r_addr),
    .o_r_value(o_r_value), .o_r_valid(o_r_valid), .o_r_err(o_r_err),
    .i_status(i_status), .o_mem(o_mem), .o_commit(o_commit), .o_locked(o_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wEn;
    logic [WW-1:0] wAddr;
    logic [W-1:0]  wVal;
    logic [RW-1:0] wLane;
    logic          rEn;
    logic [WW-1:0] rAddr;
    logic          expValid;
    logic [W-1:0]  expRVal;
    logic          expErr;
    logic          expCommit;
    logic          expLocked;
    int            memIdx;
    logic [W-1:0]  expMem;
  } vector_t;

  vector_t vecs [$];

  function automatic vector_t mk(logic wEn, logic [WW-1:0] wAddr, logic [W-1:0] wVal,
                                 logic [RW-1:0] wLane, logic rEn, logic [WW-1:0] rAddr,
                                 logic [W-1:0] expRVal, logic expErr, logic expCommit,
                                 logic expLocked, int memIdx, logic [W-1:0] expMem);
    vector_t v;
    v.wEn = wEn; v.wAddr = wAddr; v.wVal = wVal; v.wLane = wLane;
    v.rEn = rEn; v.rAddr = rAddr; v.expValid = rEn; v.expRVal = expRVal;
    v.expErr = expErr; v.expCommit = expCommit; v.expLocked = expLocked;
    v.memIdx = memIdx; v.expMem = expMem;
    return v;
  endfunction

  task automatic compare(input string nm, input int idx, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s (step %0d): actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    i_w_en    = v.wEn;
    i_w_addr  = v.wAddr;
    i_w_value = v.wVal;
    i_w_lane  = v.wLane;
    i_r_en    = v.rEn;
    i_r_addr  = v.rAddr;
  endtask

  task automatic checkOutput(input vector_t v, input int idx);
    compare("r_valid", idx, W'(o_r_valid), W'(v.expValid));
    compare("r_value", idx, o_r_value, v.expRVal);
    compare("r_err", idx, W'(o_r_err), W'(v.expErr));
    compare("commit", idx, W'(o_commit), W'(v.expCommit));
    compare("locked", idx, W'(o_locked), W'(v.expLocked));
    compare("mem", idx, o_mem[v.memIdx], v.expMem);
  endtask

  task automatic idleInputs();
    i_w_en = 1'b0; i_w_addr = '0; i_w_value = '0; i_w_lane = '0;
    i_r_en = 1'b0; i_r_addr = '0;
  endtask

  initial begin
    logic [W-1:0] m3s, m5, m2, m6s, m7s, cf;
    idleInputs();
    i_status[0] = 32'h0123_4567;
    i_status[1] = 32'hCAFE_F00D;
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;

    for (int r = 0; r < RD; r++) compare("reset_mem", r, o_mem[r], '0);
    compare("reset_valid", 0, W'(o_r_valid), '0);
    compare("reset_value", 0, o_r_value, '0);

    m3s = SHADOW ? 32'h0 : 32'h00BB_00DD;
    m5  = SHADOW ? 32'h0 : 32'h1234_5678;
    m2  = SHADOW ? 32'h0 : 32'h11;
    m6s = SHADOW ? 32'h0 : 32'h55;
    m7s = SHADOW ? 32'h0 : 32'h77;
    cf  = SHADOW ? 32'h1 : 32'h0;

    //           wEn   wAddr  wVal           lane     rEn   rAddr  expRVal        err   commit    lock idx  mem
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd0,  32'h0,         1'b0, 1'b0,     1'b0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd16, 32'h0,         1'b0, 1'b0,     1'b0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd17, 32'h0,         1'b0, 1'b0,     1'b0, 0, 32'h0));
    vecs.push_back(mk(1'b1, 8'd3,  32'hAABBCCDD,  4'h5, 1'b0, 8'd0,  32'h0,         1'b0, 1'b0,     1'b0, 3, m3s));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd3,  32'h00BB00DD,  1'b0, 1'b0,     1'b0, 3, m3s));
    vecs.push_back(mk(1'b1, 8'd16, 32'h1,         4'h1, 1'b0, 8'd0,  32'h00BB00DD,  1'b0, cf[0],    1'b0, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b0, 8'd0,  32'h00BB00DD,  1'b0, 1'b0,     1'b0, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b1, 8'd5,  32'h12345678,  4'hF, 1'b0, 8'd0,  32'h00BB00DD,  1'b0, 1'b0,     1'b0, 5, m5));
    vecs.push_back(mk(1'b1, 8'd16, 32'h2,         4'h1, 1'b0, 8'd0,  32'h00BB00DD,  1'b0, 1'b0,     1'b0, 5, m5));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd5,  m5,            1'b0, 1'b0,     1'b0, 5, m5));
    vecs.push_back(mk(1'b1, 8'd2,  32'h11,        4'hF, 1'b1, 8'd2,  32'h0,         1'b0, 1'b0,     1'b0, 2, m2));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd2,  32'h11,        1'b0, 1'b0,     1'b0, 2, m2));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd19, 32'hCAFEF00D,  1'b0, 1'b0,     1'b0, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd18, 32'h01234567,  1'b0, 1'b0,     1'b0, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'hFF, 32'h0,         1'b1, 1'b0,     1'b0, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd20, 32'h0,         1'b1, 1'b0,     1'b0, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b1, 8'd16, 32'h4,         4'h2, 1'b0, 8'd0,  32'h0,         1'b0, 1'b0,     1'b0, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd17, 32'h1,         1'b0, 1'b0,     1'b0, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b1, 8'd17, 32'hFF,        4'hF, 1'b1, 8'd17, 32'h1,         1'b0, 1'b0,     1'b0, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd17, 32'h2,         1'b0, 1'b0,     1'b0, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b1, 8'd6,  32'h55,        4'hF, 1'b0, 8'd0,  32'h2,         1'b0, 1'b0,     1'b0, 6, m6s));
    vecs.push_back(mk(1'b1, 8'd16, 32'h3,         4'h1, 1'b0, 8'd0,  32'h2,         1'b0, cf[0],    1'b0, 6, 32'h55));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd6,  32'h55,        1'b0, 1'b0,     1'b0, 6, 32'h55));
    vecs.push_back(mk(1'b1, 8'd7,  32'h77,        4'hF, 1'b0, 8'd0,  32'h55,        1'b0, 1'b0,     1'b0, 7, m7s));
    vecs.push_back(mk(1'b1, 8'd16, 32'h5,         4'h1, 1'b0, 8'd0,  32'h55,        1'b0, cf[0],    1'b1, 7, 32'h77));
    vecs.push_back(mk(1'b1, 8'd0,  32'hFFFFFFFF,  4'hF, 1'b0, 8'd0,  32'h55,        1'b0, 1'b0,     1'b1, 0, 32'h0));
    vecs.push_back(mk(1'b1, 8'd16, 32'h1,         4'h1, 1'b0, 8'd0,  32'h55,        1'b0, 1'b0,     1'b1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd17, SHADOW ? 32'h4 : 32'h3, 1'b0, 1'b0, 1'b1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd16, 32'h4,         1'b0, 1'b0,     1'b1, 0, 32'h0));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd0,  32'h0,         1'b0, 1'b0,     1'b1, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b1, 8'd16, 32'h2,         4'h1, 1'b0, 8'd0,  32'h0,         1'b0, 1'b0,     1'b1, 3, 32'h00BB00DD));
    vecs.push_back(mk(1'b0, 8'd0,  32'h0,         4'h0, 1'b1, 8'd17, SHADOW ? 32'h5 : 32'h3, 1'b0, 1'b0, 1'b1, 3, 32'h00BB00DD));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
    end

    // Error counter saturation: hammer an unmapped address well past 255.
    idleInputs();
    i_w_en = 1'b1; i_w_addr = 8'hFF; i_w_lane = 4'hF;
    repeat (260) @(negedge clk);
    idleInputs();
    i_r_en = 1'b1; i_r_addr = 8'd17;
    @(negedge clk);
    compare("errc_sat", 100, o_r_value, 32'd255);
    compare("errc_sat_valid", 100, W'(o_r_valid), 32'd1);

    // Reset landing right after a read is sampled drops the response.
    i_r_en = 1'b1; i_r_addr = 8'd3;
    @(posedge clk);
    #1 i_reset = 1'b1;
    i_r_en = 1'b0;
    @(negedge clk);
    compare("rst_drop_valid", 101, W'(o_r_valid), '0);
    compare("rst_value", 101, o_r_value, '0);
    compare("rst_locked", 101, W'(o_locked), '0);
    compare("rst_mem3", 101, o_mem[3], '0);
    i_reset = 1'b0;
    i_r_en = 1'b1; i_r_addr = 8'd17;
    @(negedge clk);
    compare("rst_errc", 102, o_r_value, '0);
    compare("rst_errc_valid", 102, W'(o_r_valid), 32'd1);
    idleInputs();
    @(negedge clk);
    compare("valid_drops", 103, W'(o_r_valid), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
